// File: rtl/hyster_pkg.sv
// Shared types and constants for the hysteresis window sequencer.
package hyster_pkg;

  localparam int DEF_DSIZE = 4;

  localparam logic [3:0] DEF_THRESH = 4'd1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Row-major tap indices of the 3x3 window (0 = top-left, 4 = center).
  localparam int NUM_TAPS   = 9;
  localparam int TAP_CENTER = 4;
  // Right-hand column, filled by each newly accepted pixel.
  localparam int TAP_TOP_R  = 2;
  localparam int TAP_MID_R  = 5;
  localparam int TAP_BOT_R  = 8;

endpackage

// File: rtl/hyster_window_ctrl_if.sv
// Pixel-in / window-out bundle of the hysteresis window sequencer.
//
// Handshake: a pixel transfers on every rising clock edge where i_valid is 1.
// There is no ready; the sequencer always accepts. i_sof and i_pixel and
// i_seg_width are only meaningful while i_valid is 1. o_win_valid is a
// one-cycle strobe qualifying o_win/o_cx/o_cy, which hold between strobes.
interface hyster_window_ctrl_if import hyster_pkg::*; #(
  parameter int DSIZE = DEF_DSIZE
) ();

  logic                   i_valid;
  logic                   i_sof;
  logic [DSIZE-1:0]       i_pixel;
  logic [3:0]             i_seg_width;

  logic [NUM_TAPS*DSIZE-1:0] o_win;
  logic                   o_win_valid;
  logic [9:0]             o_cx;
  logic [8:0]             o_cy;
  logic [3:0]             o_thresh;
  logic                   o_frame_done;
  logic                   o_err_sof;
  state_e                 o_dbg_state;

  modport slave (
    input  i_valid, i_sof, i_pixel, i_seg_width,
    output o_win, o_win_valid, o_cx, o_cy, o_thresh,
           o_frame_done, o_err_sof, o_dbg_state
  );

  modport master (
    output i_valid, i_sof, i_pixel, i_seg_width,
    input  o_win, o_win_valid, o_cx, o_cy, o_thresh,
           o_frame_done, o_err_sof, o_dbg_state
  );

endinterface

// File: rtl/hyster_linebuf.sv
// Two-row line buffer: simple dual-port RAM, one word per column,
// synchronous read with a read enable so the output holds between reads.
module hyster_linebuf #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [9:0]       i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [9:0]       i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Column counters never exceed DEPTH-1, so the upper address bits are zero.
  if (AW < 10) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^{i_raddr[9:AW], i_waddr[9:AW]};
  end

  // Storage write and registered read; no reset so the array maps to block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr[AW-1:0]] <= i_wdata;
    end
    if (i_re) begin
      rdata_q <= mem_q[i_raddr[AW-1:0]];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/hyster_window_ctrl.sv
// Raster-to-3x3-window sequencer with a frame-latched strong threshold.
module hyster_window_ctrl import hyster_pkg::*; #(
  parameter int DSIZE = DEF_DSIZE,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  hyster_window_ctrl_if.slave bus
);

  localparam int          LW       = 2 * DSIZE;
  localparam logic [9:0]  LAST_COL = 10'(IMG_W - 1);
  localparam logic [8:0]  LAST_ROW = 9'(IMG_H - 1);

  state_e state_q, state_d;
  logic [9:0] col_q, col_d;
  logic [8:0] row_q, row_d;
  logic [3:0] thresh_q, thresh_d;
  // Element 0 sits in the most significant bits, so the packed array is
  // directly the o_win tap layout.
  logic [0:NUM_TAPS-1][DSIZE-1:0] win_q, win_d;
  logic [NUM_TAPS*DSIZE-1:0] owin_q, owin_d;
  logic       valid_q, valid_d;
  logic [9:0] cx_q, cx_d;
  logic [8:0] cy_q, cy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic [9:0]    pos_x;
  logic [8:0]    pos_y;
  logic          take;
  logic [LW-1:0] lb_rdata;
  logic [LW-1:0] lb_wdata;
  logic [DSIZE-1:0] lb_top;
  logic [DSIZE-1:0] lb_mid;

  // Word layout: upper half = row y-2, lower half = row y-1.
  assign lb_top   = lb_rdata[LW-1 -: DSIZE];
  assign lb_mid   = lb_rdata[DSIZE-1:0];
  assign lb_wdata = {lb_mid, bus.i_pixel};

  // The read address is the column of the next pixel, so the word is already
  // registered when that pixel arrives; it only advances on accepted pixels.
  hyster_linebuf #(
    .DEPTH (IMG_W),
    .WIDTH (LW)
  ) u_linebuf (
    .i_clk   (i_clk),
    .i_we    (take),
    .i_waddr (pos_x),
    .i_wdata (lb_wdata),
    .i_re    (take),
    .i_raddr (col_d),
    .o_rdata (lb_rdata)
  );

  // Next-state: acceptance, raster counters, window shift and output strobes.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    thresh_d = thresh_q;
    win_d    = win_q;
    owin_d   = owin_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    pos_x    = col_q;
    pos_y    = row_q;
    take     = 1'b0;

    if (bus.i_valid) begin
      if (bus.i_sof) begin
        // Any sof restarts at (0,0); in S_RUN the old frame was cut short.
        take     = 1'b1;
        pos_x    = 10'd0;
        pos_y    = 9'd0;
        thresh_d = bus.i_seg_width;
        err_d    = (state_q == S_RUN);
        state_d  = S_RUN;
      end else if (state_q == S_RUN) begin
        take = 1'b1;
      end
    end

    if (take) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[TAP_TOP_R] = lb_top;
      win_d[TAP_MID_R] = lb_mid;
      win_d[TAP_BOT_R] = bus.i_pixel;

      // Only windows whose nine taps all come from this frame are emitted.
      if (pos_x >= 10'd2 && pos_y >= 9'd2) begin
        valid_d = 1'b1;
        owin_d  = win_d;
        cx_d    = pos_x - 10'd1;
        cy_d    = pos_y - 9'd1;
      end

      if (pos_x == LAST_COL) begin
        col_d = 10'd0;
        if (pos_y == LAST_ROW) begin
          row_d   = 9'd0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          row_d = pos_y + 9'd1;
        end
      end else begin
        col_d = pos_x + 10'd1;
        row_d = pos_y;
      end
    end
  end

  // State, counter and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      col_q    <= 10'd0;
      row_q    <= 9'd0;
      thresh_q <= DEF_THRESH;
      win_q    <= '0;
      owin_q   <= '0;
      valid_q  <= 1'b0;
      cx_q     <= 10'd0;
      cy_q     <= 9'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      thresh_q <= thresh_d;
      win_q    <= win_d;
      owin_q   <= owin_d;
      valid_q  <= valid_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_win        = owin_q;
  assign bus.o_win_valid  = valid_q;
  assign bus.o_cx         = cx_q;
  assign bus.o_cy         = cy_q;
  assign bus.o_thresh     = thresh_q;
  assign bus.o_frame_done = done_q;
  assign bus.o_err_sof    = err_q;
  assign bus.o_dbg_state  = state_q;

endmodule

// File: tb/tb_hyster_window_ctrl.sv
// Directed bench for hyster_window_ctrl on a 5x4 image.
module tb_hyster_window_ctrl;
  import hyster_pkg::*;

  localparam int DS = 4;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int WW = 9 * DS;
  localparam int EW = WW + 19;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hyster_window_ctrl_if #(.DSIZE(DS)) bus ();

  hyster_window_ctrl #(
    .DSIZE (DS),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [3:0] img [H][W];
  int tx, ty;
  bit m_run;
  logic [3:0] exp_thresh;
  bit exp_done, exp_err;
  logic [WW-1:0] last_win;
  logic [9:0] last_cx;
  logic [8:0] last_cy;
  int win_count  = 0;
  int done_count = 0;
  int err_count  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_run      = 1'b0;
    tx         = 0;
    ty         = 0;
    exp_thresh = 4'd1;
    exp_done   = 1'b0;
    exp_err    = 1'b0;
    last_win   = '0;
    last_cx    = '0;
    last_cy    = '0;
  endtask

  task automatic model_accept(input bit sof, input logic [3:0] seg, input logic [3:0] pix);
    int x, y;
    logic [WW-1:0] w;
    if (sof) begin
      if (m_run) exp_err = 1'b1;
      m_run      = 1'b1;
      exp_thresh = seg;
      tx = 0;
      ty = 0;
    end else if (!m_run) begin
      return;
    end
    x = tx;
    y = ty;
    img[y][x] = pix;
    if (x >= 2 && y >= 2) begin
      for (int k = 0; k < 9; k++) w[WW-1-4*k -: 4] = img[y-2+k/3][x-2+k%3];
      exp_q.push_back({w, 10'(x-1), 9'(y-1)});
    end
    if (x == W-1) begin
      tx = 0;
      if (y == H-1) begin
        ty = 0;
        exp_done = 1'b1;
        m_run = 1'b0;
      end else begin
        ty = y + 1;
      end
    end else begin
      tx = x + 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [3:0] pix_at(input int idx);
    return 4'((4 * (idx / W) + (idx % W)) % 16);
  endfunction

  task automatic send(input bit sof, input logic [3:0] seg, input logic [3:0] pix);
    @(negedge clk);
    bus.i_valid     = 1'b1;
    bus.i_sof       = sof;
    bus.i_pixel     = pix;
    bus.i_seg_width = seg;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    model_accept(sof, seg, pix);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [3:0] seg, input int duty);
    for (int i = 0; i < W*H; i++) begin
      int g = 0;
      while (duty < 100 && $urandom_range(0, 99) >= duty && g < 20) begin
        @(negedge clk);
        g++;
      end
      send(i == 0, seg, pix_at(i));
    end
  endtask

  // ---------------- monitor: per-cycle comparison against the model ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        last_win = e[EW-1 -: WW];
        last_cx  = e[18:9];
        last_cy  = e[8:0];
        chk("win_valid", 64'(bus.o_win_valid), 64'd1);
        win_count++;
      end else begin
        chk("win_valid_idle", 64'(bus.o_win_valid), 64'd0);
      end
      chk("win", 64'(bus.o_win), 64'(last_win));
      chk("cx", 64'(bus.o_cx), 64'(last_cx));
      chk("cy", 64'(bus.o_cy), 64'(last_cy));
      chk("frame_done", 64'(bus.o_frame_done), 64'(exp_done));
      if (exp_done) done_count++;
      exp_done = 1'b0;
      chk("err_sof", 64'(bus.o_err_sof), 64'(exp_err));
      if (exp_err) err_count++;
      exp_err = 1'b0;
      chk("thresh", 64'(bus.o_thresh), 64'(exp_thresh));
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.i_valid     = 1'b0;
    bus.i_sof       = 1'b0;
    bus.i_pixel     = '0;
    bus.i_seg_width = '0;
    model_reset();
    idle(2);

    // Reset state
    chk("rst_win", 64'(bus.o_win), 64'd0);
    chk("rst_valid", 64'(bus.o_win_valid), 64'd0);
    chk("rst_cx", 64'(bus.o_cx), 64'd0);
    chk("rst_cy", 64'(bus.o_cy), 64'd0);
    chk("rst_thresh", 64'(bus.o_thresh), 64'd1);
    chk("rst_done", 64'(bus.o_frame_done), 64'd0);
    chk("rst_err", 64'(bus.o_err_sof), 64'd0);
    chk("rst_state", 64'(bus.o_dbg_state), 64'(S_IDLE));
    rst_n = 1'b1;
    idle(1);

    // Pixels without sof are dropped
    for (int i = 0; i < 6; i++) send(1'b0, 4'd9, pix_at(i));
    idle(2);
    chk("nosof_thresh", 64'(bus.o_thresh), 64'd1);
    chk("nosof_wins", 64'(win_count), 64'd0);
    chk("nosof_state", 64'(bus.o_dbg_state), 64'(S_IDLE));

    // Full-rate frame, threshold 3
    send_frame(4'd3, 100);
    idle(2);
    chk("f1_wins", 64'(win_count), 64'd6);
    chk("f1_done", 64'(done_count), 64'd1);
    chk("f1_thresh", 64'(bus.o_thresh), 64'd3);
    chk("f1_last_win", 64'(bus.o_win), 64'h678ABCEF0);
    chk("f1_last_cx", 64'(bus.o_cx), 64'd3);
    chk("f1_last_cy", 64'(bus.o_cy), 64'd2);
    chk("f1_state", 64'(bus.o_dbg_state), 64'(S_IDLE));

    // Same frame with ~30% valid duty
    send_frame(4'd3, 30);
    idle(2);
    chk("f2_wins", 64'(win_count), 64'd12);
    chk("f2_done", 64'(done_count), 64'd2);

    // Threshold request changes mid-frame; latched value must not move
    for (int i = 0; i <= 12; i++) send(i == 0, (i == 0) ? 4'd3 : 4'd7, pix_at(i));
    idle(3);
    chk("f3_first_win", 64'(bus.o_win), 64'h01245689A);
    chk("f3_first_cx", 64'(bus.o_cx), 64'd1);
    chk("f3_first_cy", 64'(bus.o_cy), 64'd1);
    chk("f3_mid_thresh", 64'(bus.o_thresh), 64'd3);
    chk("f3_state", 64'(bus.o_dbg_state), 64'(S_RUN));
    for (int i = 13; i < W*H; i++) send(1'b0, 4'd7, pix_at(i));
    idle(2);
    chk("f3_end_thresh", 64'(bus.o_thresh), 64'd3);
    chk("f3_wins", 64'(win_count), 64'd18);
    chk("f3_done", 64'(done_count), 64'd3);

    // Next sof picks up 7; then an early sof at pixel 9 reloads 5
    send(1'b1, 4'd7, pix_at(0));
    idle(1);
    chk("f4_thresh", 64'(bus.o_thresh), 64'd7);
    for (int i = 1; i <= 8; i++) send(1'b0, 4'd2, pix_at(i));
    send(1'b1, 4'd5, pix_at(0));
    idle(1);
    chk("early_thresh", 64'(bus.o_thresh), 64'd5);
    chk("early_err_count", 64'(err_count), 64'd1);
    chk("early_no_done", 64'(done_count), 64'd3);
    for (int i = 1; i < W*H; i++) send(1'b0, 4'd2, pix_at(i));
    idle(2);
    chk("f5_wins", 64'(win_count), 64'd24);
    chk("f5_done", 64'(done_count), 64'd4);
    chk("f5_err_count", 64'(err_count), 64'd1);

    // Asynchronous reset while running
    for (int i = 0; i <= 12; i++) send(i == 0, 4'd6, pix_at(i));
    idle(1);
    chk("f6_wins", 64'(win_count), 64'd25);
    chk("f6_state", 64'(bus.o_dbg_state), 64'(S_RUN));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_win", 64'(bus.o_win), 64'd0);
    chk("arst_valid", 64'(bus.o_win_valid), 64'd0);
    chk("arst_cx", 64'(bus.o_cx), 64'd0);
    chk("arst_cy", 64'(bus.o_cy), 64'd0);
    chk("arst_thresh", 64'(bus.o_thresh), 64'd1);
    chk("arst_done", 64'(bus.o_frame_done), 64'd0);
    chk("arst_err", 64'(bus.o_err_sof), 64'd0);
    chk("arst_state", 64'(bus.o_dbg_state), 64'(S_IDLE));
    idle(2);
    rst_n = 1'b1;
    for (int i = 13; i <= 15; i++) send(1'b0, 4'd8, pix_at(i));
    idle(3);
    chk("post_rst_wins", 64'(win_count), 64'd25);
    chk("post_rst_thresh", 64'(bus.o_thresh), 64'd1);
    chk("post_rst_state", 64'(bus.o_dbg_state), 64'(S_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
